// File: rtl/ysyx_220066_id_stage.sv
// Registered RV32/RV64 instruction-decode stage.
// Takes one fetched instruction per cycle over valid/ready and presents the
// decoded control word from an output register one cycle later. An ebreak or
// an illegal instruction parks the stage in HALT until flush.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | accepting instructions whenever the output slot can drain
//   HALT  | ebreak/illegal accepted; intake blocked until flush
module ysyx_220066_id_stage #(
    parameter int XLEN  = 64,
    parameter int M_EXT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            alu_a_src,
    output logic [1:0]      alu_b_src,
    output logic [5:0]      alu_ctr,
    output logic [2:0]      branch,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            mem_to_reg,
    output logic            reg_wr,
    output logic [2:0]      mem_op,
    output logic            done,
    output logic            error
);

    localparam bit IS_RV64 = (XLEN == 64);
    localparam bit HAS_M   = (M_EXT != 0);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_OP32   = 5'b01110;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // instruction fields
    logic [4:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;

    assign w_opc = in_instr[6:2];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    // immediates built at 64 bits and truncated to XLEN, so RV32 needs no
    // zero-width replication
    logic [63:0] w_imm_i64;
    logic [63:0] w_imm_s64;
    logic [63:0] w_imm_b64;
    logic [63:0] w_imm_u64;
    logic [63:0] w_imm_j64;

    assign w_imm_i64 = {{52{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b64 = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u64 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
    assign w_imm_j64 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};

    // raw decode results before illegal-instruction masking
    logic [XLEN-1:0] w_imm;
    logic            w_a_src;
    logic [1:0]      w_b_src;
    logic [5:0]      w_alu;
    logic [2:0]      w_branch_raw;
    logic            w_mem_rd_raw;
    logic            w_mem_wr_raw;
    logic            w_mem_to_reg;
    logic            w_reg_wr_raw;
    logic            w_done;
    logic            w_illegal;

    // opcode decode into the control word plus legality
    always_comb begin
        w_imm        = '0;
        w_a_src      = 1'b0;
        w_b_src      = 2'd0;
        w_alu        = 6'd0;
        w_branch_raw = 3'b000;
        w_mem_rd_raw = 1'b0;
        w_mem_wr_raw = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_wr_raw = 1'b0;
        w_done       = 1'b0;
        w_illegal    = 1'b0;

        case (w_opc)
            OPC_LUI: begin
                w_imm        = w_imm_u64[XLEN-1:0];
                w_b_src      = 2'd2;
                w_alu        = 6'b001111;
                w_reg_wr_raw = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm        = w_imm_u64[XLEN-1:0];
                w_a_src      = 1'b1;
                w_b_src      = 2'd2;
                w_reg_wr_raw = 1'b1;
            end
            OPC_JAL: begin
                w_imm        = w_imm_j64[XLEN-1:0];
                w_a_src      = 1'b1;
                w_b_src      = 2'd1;
                w_branch_raw = 3'b001;
                w_reg_wr_raw = 1'b1;
            end
            OPC_JALR: begin
                w_imm        = w_imm_i64[XLEN-1:0];
                w_a_src      = 1'b1;
                w_b_src      = 2'd1;
                w_branch_raw = 3'b010;
                w_reg_wr_raw = 1'b1;
                w_illegal    = (w_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_imm   = w_imm_b64[XLEN-1:0];
                w_b_src = 2'd0;
                case (w_f3)
                    3'b000: begin w_branch_raw = 3'b100; w_alu = 6'b000010; end
                    3'b001: begin w_branch_raw = 3'b101; w_alu = 6'b000010; end
                    3'b100: begin w_branch_raw = 3'b110; w_alu = 6'b000011; end
                    3'b101: begin w_branch_raw = 3'b111; w_alu = 6'b000011; end
                    3'b110: begin w_branch_raw = 3'b110; w_alu = 6'b000010; end
                    3'b111: begin w_branch_raw = 3'b111; w_alu = 6'b000010; end
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_imm        = w_imm_i64[XLEN-1:0];
                w_b_src      = 2'd2;
                w_mem_rd_raw = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_wr_raw = 1'b1;
                if (IS_RV64) begin
                    w_illegal = (w_f3 == 3'b111);
                end else begin
                    w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
                end
            end
            OPC_STORE: begin
                w_imm        = w_imm_s64[XLEN-1:0];
                w_b_src      = 2'd2;
                w_mem_wr_raw = 1'b1;
                if (IS_RV64) begin
                    w_illegal = w_f3[2];
                end else begin
                    w_illegal = w_f3[2] || (w_f3[1:0] == 2'b11);
                end
            end
            OPC_OPIMM: begin
                w_imm        = w_imm_i64[XLEN-1:0];
                w_b_src      = 2'd2;
                w_alu        = {2'b00, w_f7[5] & (w_f3 == 3'b101), w_f3};
                w_reg_wr_raw = 1'b1;
                // shifts: funct6 pins the shift kind, shamt[5] only exists on RV64
                if (w_f3 == 3'b001) begin
                    w_illegal = (in_instr[31:26] != 6'b000000);
                end else if (w_f3 == 3'b101) begin
                    w_illegal = (in_instr[31:26] != 6'b000000) &&
                                (in_instr[31:26] != 6'b010000);
                end
                if (!IS_RV64 && (w_f3[1:0] == 2'b01) && in_instr[25]) begin
                    w_illegal = 1'b1;
                end
            end
            OPC_OP: begin
                w_b_src      = 2'd0;
                w_alu        = {w_f7[0], 1'b0, w_f7[5], w_f3};
                w_reg_wr_raw = 1'b1;
                case (w_f7)
                    7'b0000000: w_illegal = 1'b0;
                    7'b0100000: w_illegal = 1'b0;
                    7'b0000001: w_illegal = !HAS_M;
                    default:    w_illegal = 1'b1;
                endcase
            end
            OPC_OPIMM32: begin
                w_imm        = w_imm_i64[XLEN-1:0];
                w_b_src      = 2'd2;
                w_alu        = {2'b01, w_f7[5] & (w_f3 == 3'b101), w_f3};
                w_reg_wr_raw = 1'b1;
                w_illegal    = !IS_RV64 ||
                               !((w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b101));
            end
            OPC_OP32: begin
                w_b_src      = 2'd0;
                w_alu        = {w_f7[0], 1'b1, w_f7[5], w_f3};
                w_reg_wr_raw = 1'b1;
                case (w_f7)
                    7'b0000000: w_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                                              (w_f3 == 3'b101));
                    7'b0100000: w_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
                    7'b0000001: w_illegal = !HAS_M || (w_f3 == 3'b001) ||
                                            (w_f3 == 3'b010) || (w_f3 == 3'b011);
                    default:    w_illegal = 1'b1;
                endcase
                if (!IS_RV64) begin
                    w_illegal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                w_b_src   = 2'd1;
                w_done    = (in_instr == EBREAK);
                w_illegal = (in_instr != EBREAK);
            end
            default: w_illegal = 1'b1;
        endcase

        if (in_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end
    end

    // an illegal instruction must not cause any architectural side effect
    logic [2:0] w_branch;
    logic       w_mem_rd;
    logic       w_mem_wr;
    logic       w_reg_wr;

    assign w_branch = w_illegal ? 3'b000 : w_branch_raw;
    assign w_mem_rd = w_mem_rd_raw & ~w_illegal;
    assign w_mem_wr = w_mem_wr_raw & ~w_illegal;
    assign w_reg_wr = w_reg_wr_raw & ~w_illegal;

    logic r_out_valid;
    logic w_in_ready;
    logic w_accept;

    assign w_accept = in_valid & w_in_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state and intake-ready logic
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_RUN: begin
                w_in_ready = ~flush & (~r_out_valid | out_ready);
                if (in_valid && w_in_ready && (w_done || w_illegal)) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (flush) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // output-valid flag: flush wins, then accept, then drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_a_src;
    logic [1:0]      r_b_src;
    logic [5:0]      r_alu;
    logic [2:0]      r_branch;
    logic            r_mem_rd;
    logic            r_mem_wr;
    logic            r_mem_to_reg;
    logic            r_reg_wr;
    logic [2:0]      r_mem_op;
    logic            r_done;
    logic            r_error;

    // payload register: loads only on accept, otherwise holds (also across flush)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_a_src      <= 1'b0;
            r_b_src      <= '0;
            r_alu        <= '0;
            r_branch     <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg_wr     <= 1'b0;
            r_mem_op     <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else if (w_accept) begin
            r_pc         <= in_pc;
            r_imm        <= w_imm;
            r_rs1        <= in_instr[19:15];
            r_rs2        <= in_instr[24:20];
            r_rd         <= in_instr[11:7];
            r_a_src      <= w_a_src;
            r_b_src      <= w_b_src;
            r_alu        <= w_alu;
            r_branch     <= w_branch;
            r_mem_rd     <= w_mem_rd;
            r_mem_wr     <= w_mem_wr;
            r_mem_to_reg <= w_mem_to_reg;
            r_reg_wr     <= w_reg_wr;
            r_mem_op     <= w_f3;
            r_done       <= w_done;
            r_error      <= w_illegal;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_pc     = r_pc;
    assign imm        = r_imm;
    assign rs1        = r_rs1;
    assign rs2        = r_rs2;
    assign rd         = r_rd;
    assign alu_a_src  = r_a_src;
    assign alu_b_src  = r_b_src;
    assign alu_ctr    = r_alu;
    assign branch     = r_branch;
    assign mem_rd     = r_mem_rd;
    assign mem_wr     = r_mem_wr;
    assign mem_to_reg = r_mem_to_reg;
    assign reg_wr     = r_reg_wr;
    assign mem_op     = r_mem_op;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_ysyx_220066_id_stage.sv
// Directed bench for the decode stage: a default RV64+M instance carries the
// handshake, halt and reset scenarios; an RV32 instance and an RV64 no-M
// instance share a second stimulus stream for parameter-dependent legality.
module tb_ysyx_220066_id_stage;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // main instance (XLEN=64, M_EXT=1)
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc, out_pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        alu_a_src, mem_rd, mem_wr, mem_to_reg, reg_wr, done, error;
    logic [1:0]  alu_b_src;
    logic [5:0]  alu_ctr;
    logic [2:0]  branch, mem_op;

    // shared stimulus for the secondary instances
    logic        s_valid, s_flush, s_out_ready;
    logic [31:0] s_instr;
    logic [63:0] s_pc;

    // RV32 instance outputs
    logic        a_in_ready, a_out_valid, a_a_src, a_mem_rd, a_mem_wr, a_mem_to_reg, a_reg_wr, a_done, a_error;
    logic [31:0] a_out_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [1:0]  a_b_src;
    logic [5:0]  a_alu;
    logic [2:0]  a_branch, a_mem_op;

    // RV64 without M instance outputs
    logic        b_in_ready, b_out_valid, b_a_src, b_mem_rd, b_mem_wr, b_mem_to_reg, b_reg_wr, b_done, b_error;
    logic [63:0] b_out_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [1:0]  b_b_src;
    logic [5:0]  b_alu;
    logic [2:0]  b_branch, b_mem_op;

    ysyx_220066_id_stage #(.XLEN(64), .M_EXT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .imm(imm), .rs1(rs1), .rs2(rs2),
        .rd(rd), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_ctr(alu_ctr),
        .branch(branch), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
        .reg_wr(reg_wr), .mem_op(mem_op), .done(done), .error(error)
    );

    ysyx_220066_id_stage #(.XLEN(32), .M_EXT(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(a_in_ready),
        .in_instr(s_instr), .in_pc(s_pc[31:0]), .flush(s_flush), .out_valid(a_out_valid),
        .out_ready(s_out_ready), .out_pc(a_out_pc), .imm(a_imm), .rs1(a_rs1), .rs2(a_rs2),
        .rd(a_rd), .alu_a_src(a_a_src), .alu_b_src(a_b_src), .alu_ctr(a_alu),
        .branch(a_branch), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_to_reg(a_mem_to_reg),
        .reg_wr(a_reg_wr), .mem_op(a_mem_op), .done(a_done), .error(a_error)
    );

    ysyx_220066_id_stage #(.XLEN(64), .M_EXT(0)) u_dutm0 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(b_in_ready),
        .in_instr(s_instr), .in_pc(s_pc), .flush(s_flush), .out_valid(b_out_valid),
        .out_ready(s_out_ready), .out_pc(b_out_pc), .imm(b_imm), .rs1(b_rs1), .rs2(b_rs2),
        .rd(b_rd), .alu_a_src(b_a_src), .alu_b_src(b_b_src), .alu_ctr(b_alu),
        .branch(b_branch), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_to_reg(b_mem_to_reg),
        .reg_wr(b_reg_wr), .mem_op(b_mem_op), .done(b_done), .error(b_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // present one instruction to the main instance; returns at the negedge after accept
    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic ssend(input logic [31:0] ins);
        s_valid = 1'b1;
        s_instr = ins;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic sflush();
        s_flush = 1'b1;
        @(posedge clk); #1;
        s_flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        s_valid = 1'b0; s_instr = '0; s_pc = 64'h80; s_flush = 1'b0; s_out_ready = 1'b1;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_imm", imm, 0);
        chk("rst_error", error, 0);
        chk("rst_done", done, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // basic decode: addi x1,x0,5
        send(32'h0050_0093, 64'h1000);
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", rd, 1);
        chk("addi_imm", imm, 5);
        chk("addi_bsrc", alu_b_src, 2);
        chk("addi_regwr", reg_wr, 1);
        chk("addi_alu", alu_ctr, 0);
        chk("addi_pc", out_pc, 64'h1000);

        // lui x5,0x12345
        send(32'h1234_52b7, 64'h1004);
        chk("lui_imm", imm, 64'h0000_0000_1234_5000);
        chk("lui_rd", rd, 5);
        chk("lui_alu", alu_ctr, 6'h0f);
        chk("lui_bsrc", alu_b_src, 2);

        // jal x1,-4
        send(32'hFFDF_F0EF, 64'h1008);
        chk("jal_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("jal_branch", branch, 3'b001);
        chk("jal_asrc", alu_a_src, 1);
        chk("jal_bsrc", alu_b_src, 1);

        // sd x2,8(x1)
        send(32'h0020_B423, 64'h100c);
        chk("sd_imm", imm, 8);
        chk("sd_memwr", mem_wr, 1);
        chk("sd_regwr", reg_wr, 0);
        chk("sd_memop", mem_op, 3);
        chk("sd_rs2", rs2, 2);

        // blt x1,x2,-4
        send(32'hFE20_CEE3, 64'h1010);
        chk("blt_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("blt_branch", branch, 3'b110);
        chk("blt_alu", alu_ctr, 6'b000011);
        chk("blt_regwr", reg_wr, 0);

        // sub x3,x1,x2
        send(32'h4020_81B3, 64'h1014);
        chk("sub_alu", alu_ctr, 6'b001000);
        chk("sub_bsrc", alu_b_src, 0);
        chk("sub_rs1", rs1, 1);

        // mul x3,x1,x2 with M present
        send(32'h0220_81b3, 64'h1018);
        chk("mul64_alu", alu_ctr, 6'b100000);
        chk("mul64_error", error, 0);

        // addiw x1,x0,1 on RV64
        send(32'h0010_009B, 64'h101c);
        chk("addiw64_alu", alu_ctr, 6'b010000);
        chk("addiw64_imm", imm, 1);
        chk("addiw64_error", error, 0);

        // back-pressure: three addi, execute stalls for two cycles
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 64'h200;
        @(posedge clk); #1;
        in_instr = 32'h0020_0113; in_pc = 64'h204; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_first_pc", out_pc, 64'h200);
        chk("bp_first_imm", imm, 1);
        chk("bp_stall_rdy0", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_hold_pc", out_pc, 64'h200);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_stall_rdy1", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hold2_pc", out_pc, 64'h200);
        chk("bp_release_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_instr = 32'h0030_0193; in_pc = 64'h208;
        @(negedge clk);
        chk("bp_second_pc", out_pc, 64'h204);
        chk("bp_second_rd", rd, 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_third_pc", out_pc, 64'h208);
        chk("bp_third_rd", rd, 3);
        chk("bp_third_valid", out_valid, 1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // ebreak halts; following addi waits until flush
        in_valid = 1'b1; in_instr = 32'h0010_0073; in_pc = 64'h300;
        @(posedge clk); #1;
        in_instr = 32'h0050_0093; in_pc = 64'h304; out_ready = 1'b0;
        @(negedge clk);
        chk("ebk_done", done, 1);
        chk("ebk_valid", out_valid, 1);
        chk("ebk_regwr", reg_wr, 0);
        chk("ebk_bsrc", alu_b_src, 1);
        chk("ebk_error", error, 0);
        chk("ebk_rdy", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("halt_pc", out_pc, 64'h300);
        chk("halt_rdy", in_ready, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_rdy", in_ready, 1);
        chk("flush_payload_held", done, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("resume_valid", out_valid, 1);
        chk("resume_pc", out_pc, 64'h304);
        chk("resume_imm", imm, 5);
        chk("resume_done", done, 0);

        // jalr with funct3=001 is illegal and suppresses side effects
        send(32'h0001_10E7, 64'h400);
        chk("jalr_bad_error", error, 1);
        chk("jalr_bad_regwr", reg_wr, 0);
        chk("jalr_bad_branch", branch, 0);
        chk("jalr_bad_halt_rdy", in_ready, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("jalr_flush_rdy", in_ready, 1);

        // async reset while stalled with a valid word
        out_ready = 1'b0;
        send(32'h4020_81B3, 64'h500);
        chk("ar_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_pc", out_pc, 0);
        chk("ar_rd", rd, 0);
        chk("ar_alu", alu_ctr, 0);
        chk("ar_regwr", reg_wr, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("ar_rdy", in_ready, 1);
        @(negedge clk);

        // parameter legality on the secondary instances
        ssend(32'h0001_3083);
        chk("ld32_error", a_error, 1);
        chk("ld32_regwr", a_reg_wr, 0);
        chk("ld32_memrd", a_mem_rd, 0);
        chk("ld64_error", b_error, 0);
        chk("ld64_memrd", b_mem_rd, 1);
        chk("ld64_memop", b_mem_op, 3);
        sflush();

        ssend(32'h0220_81b3);
        chk("mul_nom_error", b_error, 1);
        chk("mul_nom_regwr", b_reg_wr, 0);
        chk("mul32_error", a_error, 0);
        chk("mul32_alu", a_alu, 6'b100000);
        sflush();

        ssend(32'h0010_009B);
        chk("addiw32_error", a_error, 1);
        chk("addiw_nom_error", b_error, 0);
        chk("addiw_nom_alu", b_alu, 6'b010000);
        sflush();

        ssend(32'h0200_9093);
        chk("slli32_error", a_error, 1);
        chk("slli64_error", b_error, 0);
        chk("slli64_imm", b_imm, 64'h20);
        chk("slli64_alu", b_alu, 1);
        sflush();

        ssend(32'hFFFF_F0B7);
        chk("lui32_imm", a_imm, 32'hFFFF_F000);
        chk("lui32_error", a_error, 0);
        chk("lui64_imm", b_imm, 64'hFFFF_FFFF_FFFF_F000);
        chk("lui32_valid", a_out_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_id_stage.md
# ysyx_220066_id_stage

Registered, parametrised RV32/RV64 instruction-decode stage between the fetch stage and the execute stage. It accepts one fetched instruction per cycle over a valid/ready handshake and decodes it into the control word the datapath consumes. The control word is produced one cycle later from an output pipeline register. The stage supports optional M-extension decode, back-pressure, flush, and a halt state entered on `ebreak` or an illegal instruction.

## Interface
Parameters:
- `XLEN`, default 64: datapath width; only 32 or 64 are legal.
- `M_EXT`, default 1: when 1, MUL/DIV encodings are legal; when 0, they raise `error`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: fetch presents `in_instr`/`in_pc`.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in XLEN: instruction address.
- `flush` in 1: squash the held instruction and leave HALT.
- `out_valid` out 1: decoded word valid.
- `out_ready` in 1: execute consumes this cycle.
- `out_pc` out XLEN: registered `in_pc`.
- `imm` out XLEN: sign-extended immediate.
- `rs1`, `rs2`, `rd` out 5 each: `instr[19:15]`, `[24:20]`, `[11:7]`.
- `alu_a_src` out 1: 1 selects PC.
- `alu_b_src` out 2: 0 = rs2, 1 = constant 4, 2 = imm.
- `alu_ctr` out 6: bit 5 = M-op, bit 4 = word-op, bits 3:0 = ALU function.
- `branch` out 3: 000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 lt, 111 ge.
- `mem_rd`, `mem_wr`, `mem_to_reg`, `reg_wr` out 1 each.
- `mem_op` out 3: `funct3`.
- `done` out 1: `ebreak`.
- `error` out 1: illegal instruction.

## Operation
**Immediate formats** (all sign-extended from `instr[31]` to XLEN):
- I: `instr[31:20]`
- S: `{instr[31:25], instr[11:7]}`
- B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`
- U: `{instr[31:12], 12'b0}`
- J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`

**Decode by opcode[6:2]:**
- lui 01101: U, `b_src`=2, `alu[3:0]`=1111.
- auipc 00101: U, `a_src`=1, `b_src`=2, `alu`=0.
- jal 11011: J, `a_src`=1, `b_src`=1, `branch`=001.
- jalr 11001: I, `a_src`=1, `b_src`=1, `branch`=010; `funct3`≠000 is illegal.
- branch 11000: B, `b_src`=0.
  - beq/bne/bltu/bgeu: `alu`=0010.
  - blt/bge: `alu`=0011.
  - `funct3` 010/011 is illegal.
- load 00000: I, `b_src`=2, `mem_rd`=`mem_to_reg`=1.
  - Legal `funct3`: 000–110 when XLEN=64; 000, 001, 010, 100, 101 when XLEN=32.
- store 01000: S, `b_src`=2, `mem_wr`=1, `reg_wr`=0.
  - Legal `funct3`: 000–011 when XLEN=64; 000–010 when XLEN=32.
- op-imm 00100: I, `b_src`=2, `alu[2:0]`=`funct3`, `alu[3]`=`funct7[5]` & (`funct3`==101).
  - slli/srli require `instr[31:26]`=000000; srai requires 010000.
  - When XLEN=32, `instr[25]` must also be 0.
- op 01100: `b_src`=0, `alu[2:0]`=`funct3`, `alu[3]`=`funct7[5]`.
  - Legal `funct7`: 0000000, 0100000; 0000001 only if M_EXT.
  - `alu[5]`=`funct7[0]`.
- op-imm-32 00110 / op-32 01110: word forms, `alu[4]`=1; illegal when XLEN=32.
  - 00110 legal `funct3`: 000, 001, 101.
  - 01110 legal: add/sub/sll/srl/sra; M forms with `funct3` ∈ {000, 100, 101, 110, 111} only if M_EXT.
- system 11100: `done`=1, `reg_wr`=0, `b_src`=1; only 0x00100073 is legal.
- Any other opcode, or `instr[1:0]`≠11: `error`=1.

**On `error`:** `reg_wr`, `mem_rd`, `mem_wr` are forced to 0 and `branch` to 000 (no side effects).

**State machine** (states RUN, HALT):
- RUN → HALT when an instruction with `done` or `error` is accepted.
- HALT → RUN on `flush`.
- In HALT, `in_ready`=0; the halting instruction stays presented until consumed.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is valid on outputs after edge N.
- `in_ready` = (state==RUN) & !`flush` & (!`out_valid` | `out_ready`). It is combinational, with no dependence on `in_valid`.
- A transfer happens when `in_valid` & `in_ready`. Back-to-back transfers give full throughput.
- `out_valid`:
  - set on accept;
  - cleared when `out_ready` with no new accept;
  - cleared on `flush` (flush has priority over everything).
- While `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- The payload register loads only on accept; it holds otherwise, including after a flush.
- Reset (async, while `rst_n`=0, and after release):
  - state=RUN, `out_valid`=0;
  - all payload outputs 0 (including `error` and `done`);
  - `in_ready`=1 after release, given `flush`=0.
- Reset mid-transfer discards the held instruction.

## Test plan
- **Basic decode:** XLEN=64, send 0x00500093 (addi x1,x0,5) → next cycle `out_valid`=1, `rd`=1, `imm`=5, `b_src`=2, `reg_wr`=1, `alu`=000000.
- **Immediates:** lui 0x123452b7 → `imm`=0x0000000012345000. Then jal 0xFFDFF0EF → `imm`=-4 (0xFFFF_FFFF_FFFF_FFFC), `branch`=001.
- **Back-pressure:** stream 3 instructions with `out_ready` low for 2 cycles → outputs hold; no instruction lost or duplicated; `in_ready`=0 during the stall.
- **Halt and flush:** send 0x00100073 then addi → `done`=1, state HALT, addi not accepted. Pulse `flush` → `out_valid`=0 next cycle and addi accepted after.
- **Parameter legality:**
  - M_EXT=0, 0x022081b3 (mul) → `error`=1, `reg_wr`=0.
  - XLEN=32, 0x00013083 (ld) → `error`=1.
  - XLEN=32, addiw 0x0010009B → `error`=1.
- **Async reset:** drop `rst_n` mid-stall with `out_valid`=1 → `out_valid`=0 and all outputs 0 immediately, independent of `clk`.
